// File: rtl/serial_deserializer.sv
// LSB-first serial-to-parallel receiver with a one-entry valid/ready holding register.
// Define DESER_PARITY_EN to accept a trailing even-parity bit per word and report parity_err.
module serial_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH+1);

`ifdef DESER_PARITY_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

  state_t            state, state_next;
  logic [WIDTH-1:0]  sreg, sreg_next, word;
  logic [CW-1:0]     count_next;
  logic              accept, word_done, load;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      state     <= IDLE;
      bit_count <= '0;
      sreg      <= '0;
    end else begin
      state     <= state_next;
      bit_count <= count_next;
      sreg      <= sreg_next;
    end
  end

  // Bits enter at the MSB and move right, so after WIDTH shifts bit 0 holds the first bit.
  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    count_next = bit_count;
    word_done  = 1'b0;
    word       = sreg;
    accept     = bit_valid && !clear;
    if (accept) begin
      case (state)
        IDLE, COLLECT: begin
          sreg_next = {serial_in, sreg[WIDTH-1:1]};
          if (bit_count == CW'(WIDTH-1)) begin
`ifdef DESER_PARITY_EN
            state_next = PARITY;
            count_next = CW'(WIDTH);
`else
            state_next = IDLE;
            count_next = '0;
            word_done  = 1'b1;
            word       = sreg_next;
`endif
          end else begin
            state_next = COLLECT;
            count_next = bit_count + CW'(1);
          end
        end
`ifdef DESER_PARITY_EN
        PARITY: begin
          state_next = IDLE;
          count_next = '0;
          word_done  = 1'b1;
          word       = sreg;
        end
`endif
        default: state_next = IDLE;
      endcase
    end
    load = word_done && (!data_valid || data_ready);
  end

`ifdef DESER_PARITY_EN
  logic parity_q;
  assign parity_err = parity_q && data_valid;
`else
  assign parity_err = 1'b0;
`endif

  // A completed word is dropped (and overrun latched) only when the holder is occupied and not draining.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else if (clear) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef DESER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else if (load) begin
      data_out   <= word;
      data_valid <= 1'b1;
`ifdef DESER_PARITY_EN
      parity_q   <= (^word) ^ serial_in;
`endif
    end else if (word_done) begin
      overrun    <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_valid <= 1'b0;
    end
  end

  assign busy = (bit_count != '0);

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer against a bit-list reference model.
// Parity-specific cases are built only when DESER_PARITY_EN is defined.
module tb_serial_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH+1);
`ifdef DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0, clear = 1'b0, serial_in = 1'b0, bit_valid = 1'b0, data_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid, busy, overrun, parity_err;
  logic [CW-1:0]    bit_count;

  int total = 0;
  int bad   = 0;

  // Reference model: bits gathered so far for the current word plus the holding register contents.
  int          m_got   = 0;
  logic [31:0] m_word  = '0;
  logic [31:0] m_data  = '0;
  logic        m_valid = 1'b0;
  logic        m_ovr   = 1'b0;
  logic        m_perr  = 1'b0;

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .serial_in(serial_in),
    .bit_valid(bit_valid), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .bit_count(bit_count),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic rst_n, input logic clr, input logic bv, input logic si, input logic rdy);
    logic        done;
    logic        p;
    logic [31:0] w;
    done = 1'b0;
    p    = 1'b0;
    if (!rst_n) begin
      m_got = 0; m_word = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else if (clr) begin
      m_got = 0; m_word = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
    end else begin
      if (bv) begin
        if (m_got < WIDTH) begin
          m_word = m_word | (32'(si) << m_got);
          m_got++;
          if (m_got == WIDTH && !PAR) done = 1'b1;
        end else begin
          p    = si;
          done = 1'b1;
        end
      end
      if (done) begin
        w      = m_word;
        m_word = '0;
        m_got  = 0;
        if (!m_valid || rdy) begin
          m_data  = w;
          m_valid = 1'b1;
          m_perr  = 1'(($countones(w) % 2)) ^ p;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, then compare all outputs.
  task automatic applyStimulus(input logic rst_n, input logic clr, input logic bv, input logic si, input logic rdy);
    reset_n = rst_n; clear = clr; bit_valid = bv; serial_in = si; data_ready = rdy;
    @(posedge clock);
    modelStep(rst_n, clr, bv, si, rdy);
    #1;
    checkOutput("data_valid", 32'(data_valid), 32'(m_valid));
    checkOutput("data_out",   32'(data_out),   m_data);
    checkOutput("bit_count",  32'(bit_count),  32'(m_got));
    checkOutput("busy",       32'(busy),       32'(m_got != 0));
    checkOutput("overrun",    32'(overrun),    32'(m_ovr));
    checkOutput("parity_err", 32'(parity_err), 32'(PAR && m_perr && m_valid));
  endtask

  task automatic sendWord(input logic [7:0] value, input logic rdy_body, input logic rdy_last, input logic p);
    for (int i = 0; i < WIDTH; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, value[i], (i == WIDTH-1 && !PAR) ? rdy_last : rdy_body);
    if (PAR) applyStimulus(1'b1, 1'b0, 1'b1, p, rdy_last);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_count", 32'(bit_count), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);

    // Single word with the consumer always ready.
    sendWord(8'hA5, 1'b1, 1'b1, ^8'hA5);
    checkOutput("a5_data", 32'(data_out), 32'hA5);
    checkOutput("a5_valid", 32'(data_valid), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("a5_one_cycle", 32'(data_valid), 32'd0);

    // Back-to-back under backpressure: the second word is dropped.
    sendWord(8'h3C, 1'b0, 1'b0, ^8'h3C);
    sendWord(8'hC3, 1'b0, 1'b0, ^8'hC3);
    checkOutput("bp_data", 32'(data_out), 32'h3C);
    checkOutput("bp_valid", 32'(data_valid), 32'd1);
    checkOutput("bp_overrun", 32'(overrun), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_drain", 32'(data_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("clr_overrun", 32'(overrun), 32'd0);

    // Completion in the same cycle as the handshake of the held word.
    sendWord(8'h11, 1'b0, 1'b0, ^8'h11);
    sendWord(8'h22, 1'b0, 1'b1, ^8'h22);
    checkOutput("hs_data", 32'(data_out), 32'h22);
    checkOutput("hs_valid", 32'(data_valid), 32'd1);
    checkOutput("hs_overrun", 32'(overrun), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-word abort by clear, then by reset.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'(i & 1), 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_count", 32'(bit_count), 32'd0);
    sendWord(8'h81, 1'b1, 1'b1, ^8'h81);
    checkOutput("abort_data", 32'(data_out), 32'h81);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rst2_data", 32'(data_out), 32'd0);
    checkOutput("rst2_busy", 32'(busy), 32'd0);
    checkOutput("rst2_count", 32'(bit_count), 32'd0);

    // Gapped input: bit_valid low for 3 cycles after bit 3.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("gap_busy", 32'(busy), 32'd1);
      checkOutput("gap_count", 32'(bit_count), 32'd4);
    end
    for (int i = 4; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    if (PAR) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("gap_data", 32'(data_out), 32'hF0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DESER_PARITY_EN
    sendWord(8'h07, 1'b1, 1'b1, 1'b1);
    checkOutput("par_ok_err", 32'(parity_err), 32'd0);
    checkOutput("par_ok_data", 32'(data_out), 32'h07);
    sendWord(8'h07, 1'b1, 1'b1, 1'b0);
    checkOutput("par_bad_err", 32'(parity_err), 32'd1);
    checkOutput("par_bad_data", 32'(data_out), 32'h07);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with occasional clear and reset.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 255) != 0), ($urandom_range(0, 63) == 0),
                    ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
